// File: rtl/ov7670_cfg_pkg.sv
// Shared constants, state encoding and sizing helper for the OV7670 config ROM path.
// Used by the sequencer, the ROM and their benches.
package ov7670_cfg_pkg;

  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  localparam int DEF_DELAY_CYCLES   = 250_000;
  localparam int DEF_GAP_CYCLES     = 64;
  localparam int DEF_TIMEOUT_CYCLES = 100_000;
  localparam int DEF_ADDR_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_GAP    = 3'd5,
    ST_DELAY  = 3'd6,
    ST_DONE   = 3'd7
  } cfg_state_e;

  // One counter serves all three waits, so it is sized for the longest of them.
  function automatic int timer_width(input int d, input int g, input int t);
    int m;
    m = d;
    if (g > m) m = g;
    else       m = m;
    if (t > m) m = t;
    else       m = m;
    if (m < 2) m = 2;
    else       m = m;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/cfg_wait_timer.sv
// Cycle counter shared by the DELAY, GAP and WAIT-timeout phases of the config sequencer.
// Counts up from a clear and parks on the terminal count instead of wrapping.
module cfg_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] term,
  output logic         expired
);

  logic [W-1:0] count_r;

  // Counter register: clear wins, otherwise count until the terminal value is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != term)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == term);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and turns each {reg,data} entry into one SCCB write,
// honouring timed-delay and end-of-table markers; reports busy/done/err upward.
module ov7670_config_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int DELAY_CYCLES   = DEF_DELAY_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ADDR_W         = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_dout,
  output logic              sccb_valid,
  input  logic              sccb_ready,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_data,
  input  logic              sccb_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TMR_W = timer_width(DELAY_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]  DELAY_TC   = TMR_W'(DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GAP_TC     = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TIMEOUT_TC = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};

  cfg_state_e        state_r, next_s;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              sccb_valid_r, busy_r, done_r, err_r;
  logic [7:0]        sccb_reg_r, sccb_data_r;

  logic             start_acc_s, load_s, accept_s, incr_s, finish_s, fail_s;
  logic             tmr_clear_s, tmr_en_s, tmr_expired_s;
  logic [TMR_W-1:0] tmr_term_s;

  cfg_wait_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear_s),
    .enable  (tmr_en_s),
    .term    (tmr_term_s),
    .expired (tmr_expired_s)
  );

  // Next-state and per-cycle action decode; finishing goes straight back to IDLE.
  always_comb begin
    next_s      = state_r;
    start_acc_s = 1'b0;
    load_s      = 1'b0;
    accept_s    = 1'b0;
    incr_s      = 1'b0;
    finish_s    = 1'b0;
    fail_s      = 1'b0;
    tmr_clear_s = 1'b0;
    tmr_en_s    = 1'b0;
    tmr_term_s  = TIMEOUT_TC;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          next_s      = ST_FETCH;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_FETCH: next_s = ST_DECODE;
      ST_DECODE: begin
        if (rom_dout == CFG_END) begin
          finish_s = 1'b1;
          next_s   = ST_IDLE;
        end else if (rom_dout == CFG_DELAY) begin
          tmr_clear_s = 1'b1;
          next_s      = ST_DELAY;
        end else begin
          load_s = 1'b1;
          next_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sccb_ready) begin
          accept_s    = 1'b1;
          tmr_clear_s = 1'b1;
          next_s      = ST_WAIT;
        end else begin
          next_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        tmr_en_s   = 1'b1;
        tmr_term_s = TIMEOUT_TC;
        if (sccb_done) begin
          tmr_clear_s = 1'b1;
          next_s      = ST_GAP;
        end else if (tmr_expired_s) begin
          fail_s   = 1'b1;
          finish_s = 1'b1;
          next_s   = ST_IDLE;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_GAP, ST_DELAY: begin
        tmr_en_s   = 1'b1;
        tmr_term_s = (state_r == ST_GAP) ? GAP_TC : DELAY_TC;
        if (tmr_expired_s) begin
          // Running off the end of the table without a terminator is an error.
          if (rom_addr_r == ADDR_LAST) begin
            fail_s   = 1'b1;
            finish_s = 1'b1;
            next_s   = ST_IDLE;
          end else begin
            incr_s = 1'b1;
            next_s = ST_FETCH;
          end
        end else begin
          next_s = state_r;
        end
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // State, ROM address, SCCB request and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rom_addr_r   <= '0;
      sccb_valid_r <= 1'b0;
      sccb_reg_r   <= 8'h00;
      sccb_data_r  <= 8'h00;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r <= next_s;
      if (start_acc_s)  rom_addr_r <= '0;
      else if (incr_s)  rom_addr_r <= rom_addr_r + ADDR_W'(1);
      else              rom_addr_r <= rom_addr_r;
      if (load_s) begin
        sccb_reg_r  <= rom_dout[15:8];
        sccb_data_r <= rom_dout[7:0];
      end else begin
        sccb_reg_r  <= sccb_reg_r;
        sccb_data_r <= sccb_data_r;
      end
      if (load_s)                     sccb_valid_r <= 1'b1;
      else if (accept_s || finish_s)  sccb_valid_r <= 1'b0;
      else                            sccb_valid_r <= sccb_valid_r;
      if (start_acc_s)    busy_r <= 1'b1;
      else if (finish_s)  busy_r <= 1'b0;
      else                busy_r <= busy_r;
      if (start_acc_s)    done_r <= 1'b0;
      else if (finish_s)  done_r <= 1'b1;
      else                done_r <= done_r;
      if (start_acc_s)    err_r <= 1'b0;
      else if (fail_s)    err_r <= 1'b1;
      else                err_r <= err_r;
    end
  end

  assign rom_addr   = rom_addr_r;
  assign sccb_valid = sccb_valid_r;
  assign sccb_reg   = sccb_reg_r;
  assign sccb_data  = sccb_data_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: behavioural 1-clk ROM, SCCB master responder and
// a table-walking timing model that predicts every accept edge and the finish edge.
module tb_ov7670_config_sequencer;

  localparam int P_DELAY = 20;
  localparam int P_GAP = 4;
  localparam int P_TIMEOUT = 50;
  localparam int P_AW = 8;

  logic clk = 1'b0;
  logic rst_n, start, sccb_ready, sccb_done;
  logic [P_AW-1:0] rom_addr;
  logic [15:0] rom_dout = 16'h0000;
  logic sccb_valid, busy, done, err;
  logic [7:0] sccb_reg, sccb_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [15:0] rom_mem [256];
  bit done_en = 1'b0;
  int done_lat = 10;
  int done_due = -1;
  logic [15:0] acc_q[$];
  int acc_cyc[$];
  logic [15:0] exp_wr[$];
  int exp_acc[$];
  int exp_fin;
  bit exp_err;

  ov7670_config_sequencer #(.DELAY_CYCLES(P_DELAY), .GAP_CYCLES(P_GAP),
                            .TIMEOUT_CYCLES(P_TIMEOUT), .ADDR_W(P_AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .sccb_valid(sccb_valid), .sccb_ready(sccb_ready), .sccb_reg(sccb_reg),
    .sccb_data(sccb_data), .sccb_done(sccb_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_dout <= rom_mem[rom_addr];

  // SCCB master: log accepts (edge cyc+1 samples valid&ready), pulse done done_lat edges later.
  always begin
    @(negedge clk);
    #1;
    if (sccb_valid === 1'b1 && sccb_ready === 1'b1) begin
      acc_q.push_back({sccb_reg, sccb_data});
      acc_cyc.push_back(cyc + 1);
      if (done_en) done_due = cyc + 1 + done_lat;
    end
    sccb_done = (done_due == cyc + 1);
  end

  // Timing model: an "advance" edge e puts the next entry's address out; decode is e+2.
  task automatic model_run(input int n_edge, input int lat);
    int e;
    e = n_edge;
    exp_wr.delete(); exp_acc.delete();
    exp_err = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (rom_mem[i] == 16'hFFFF) begin
        exp_fin = e + 2;
        return;
      end
      if (rom_mem[i] == 16'hFFF0) begin
        e = e + 2 + P_DELAY;
      end else begin
        exp_wr.push_back(rom_mem[i]);
        exp_acc.push_back(e + 3);
        e = e + 3 + lat + P_GAP;
      end
    end
    exp_err = 1'b1;
    exp_fin = e;
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 256; i++) rom_mem[i] = v;
  endtask

  task automatic prep(input bit den, input int lat, input logic rdy);
    done_en = den; done_lat = lat; done_due = -1; sccb_ready = rdy;
    acc_q.delete(); acc_cyc.delete();
  endtask

  task automatic pulse_start(output int n_edge);
    @(negedge clk);
    start = 1'b1;
    n_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int seen, output bit ok);
    ok = 1'b0; seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; seen = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sccb_ready = 1'b0; sccb_done = 1'b0;
    fill_rom(16'hFFFF);
    repeat (3) @(negedge clk);
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", rom_addr); end
    total++; if (sccb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sccb_valid); end
    total++; if ({sccb_reg, sccb_data} !== 16'h0000) begin bad++; $display("FAIL reset_regdata got=%h exp=0000", {sccb_reg, sccb_data}); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b exp=000", {busy, done, err}); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({busy, sccb_valid} !== 2'b00) begin bad++; $display("FAIL idle_no_start got=%b exp=00", {busy, sccb_valid}); end
  endtask

  task automatic test_table();
    int n, seen; bit ok;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1204; rom_mem[3] = 16'hFFFF;
    prep(1'b1, 10, 1'b1);
    pulse_start(n);
    total++; if ({busy, done, err} !== 3'b100) begin bad++; $display("FAIL table_busy got=%b exp=100", {busy, done, err}); end
    model_run(n, 10);
    wait_done(exp_fin - cyc + 40, seen, ok);
    total++; if (!ok || seen !== exp_fin) begin bad++; $display("FAIL table_finish got=%0d exp=%0d", seen, exp_fin); end
    total++; if (acc_q.size() !== 2) begin bad++; $display("FAIL table_count got=%0d exp=2", acc_q.size()); end
    for (int i = 0; i < exp_wr.size() && i < acc_q.size(); i++) begin
      total++; if (acc_q[i] !== exp_wr[i]) begin bad++; $display("FAIL table_write%0d got=%h exp=%h", i, acc_q[i], exp_wr[i]); end
      total++; if (acc_cyc[i] !== exp_acc[i]) begin bad++; $display("FAIL table_acc%0d got=%0d exp=%0d", i, acc_cyc[i], exp_acc[i]); end
    end
    total++; if ({busy, done, err} !== 3'b010) begin bad++; $display("FAIL table_status got=%b exp=010", {busy, done, err}); end
  endtask

  task automatic test_random();
    int n, seen, k, lat; bit ok;
    logic [15:0] w;
    for (int it = 0; it < 4; it++) begin
      fill_rom(16'(($urandom & 32'hFFF) | 32'h1000));
      k = $urandom_range(1, 8);
      for (int i = 0; i < k; i++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w = 16'hFFF0;
        else if (w[15:8] == 8'hFF && (w[7:0] == 8'hFF || w[7:0] == 8'hF0)) w[0] = ~w[0];
        else w = w;
        if (it == 0 && i == 0) w = 16'hFF12;
        rom_mem[i] = w;
      end
      rom_mem[k] = 16'hFFFF;
      lat = $urandom_range(1, 15);
      prep(1'b1, lat, 1'b1);
      pulse_start(n);
      model_run(n, lat);
      wait_done(exp_fin - cyc + 40, seen, ok);
      total++; if (!ok || seen !== exp_fin) begin bad++; $display("FAIL rnd%0d_finish got=%0d exp=%0d", it, seen, exp_fin); end
      total++; if (acc_q.size() !== exp_wr.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, acc_q.size(), exp_wr.size()); end
      for (int i = 0; i < exp_wr.size() && i < acc_q.size(); i++) begin
        total++; if (acc_q[i] !== exp_wr[i] || acc_cyc[i] !== exp_acc[i]) begin
          bad++; $display("FAIL rnd%0d_write%0d got=%h@%0d exp=%h@%0d", it, i, acc_q[i], acc_cyc[i], exp_wr[i], exp_acc[i]);
        end
      end
      total++; if ({busy, done, err} !== 3'b010) begin bad++; $display("FAIL rnd%0d_status got=%b exp=010", it, {busy, done, err}); end
    end
  endtask

  task automatic test_stall();
    int n, seen, vcyc; bit ok;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h1234;
    prep(1'b1, 10, 1'b0);
    pulse_start(n);
    vcyc = -1;
    for (int i = 0; i < 20 && vcyc < 0; i++) begin
      if (sccb_valid === 1'b1) vcyc = cyc;
      else @(negedge clk);
    end
    // Visible after edge N+2, so the master first samples it at edge N+3.
    total++; if (vcyc !== n + 2) begin bad++; $display("FAIL stall_valid_rise got=%0d exp=%0d", vcyc, n + 2); end
    for (int i = 0; i < 30; i++) begin
      total++; if ({sccb_valid, sccb_reg, sccb_data} !== {1'b1, 16'h1234}) begin
        bad++; $display("FAIL stall_hold%0d got=%b/%h exp=1/1234", i, sccb_valid, {sccb_reg, sccb_data});
      end
      @(negedge clk);
    end
    sccb_ready = 1'b1;
    wait_done(200, seen, ok);
    total++; if (!ok || acc_q.size() !== 1) begin bad++; $display("FAIL stall_accepts got=%0d exp=1", acc_q.size()); end
    total++; if (acc_q.size() > 0 && acc_q[0] !== 16'h1234) begin bad++; $display("FAIL stall_write got=%h exp=1234", acc_q[0]); end
  endtask

  task automatic test_reset_mid();
    int n, hits;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h1234;
    prep(1'b1, 10, 1'b0);
    pulse_start(n);
    for (int i = 0; i < 20 && sccb_valid !== 1'b1; i++) @(negedge clk);
    total++; if (sccb_valid !== 1'b1) begin bad++; $display("FAIL rstmid_valid got=%b exp=1", sccb_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({sccb_valid, busy, rom_addr} !== {2'b00, 8'h00}) begin
      bad++; $display("FAIL rstmid_abort got=%b%b/%h exp=00/00", sccb_valid, busy, rom_addr);
    end
    rst_n = 1'b1;
    sccb_ready = 1'b1;
    hits = 0;
    repeat (15) begin
      @(negedge clk);
      if (sccb_valid !== 1'b0 || busy !== 1'b0) hits++;
    end
    total++; if (hits !== 0 || acc_q.size() !== 0) begin bad++; $display("FAIL rstmid_idle got=%0d/%0d exp=0/0", hits, acc_q.size()); end
  endtask

  task automatic test_timeout();
    int n, seen, hits; bit ok;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h1234;
    prep(1'b0, 10, 1'b1);
    pulse_start(n);
    wait_done(200, seen, ok);
    total++; if (acc_cyc.size() !== 1 || acc_cyc[0] !== n + 3) begin bad++; $display("FAIL tmo_accept got=%0d exp=1", acc_cyc.size()); end
    total++; if (!ok || acc_cyc.size() < 1 || seen !== acc_cyc[0] + P_TIMEOUT) begin
      bad++; $display("FAIL tmo_finish got=%0d exp=%0d", seen, n + 3 + P_TIMEOUT);
    end
    total++; if ({busy, done, err} !== 3'b011) begin bad++; $display("FAIL tmo_status got=%b exp=011", {busy, done, err}); end
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (sccb_valid !== 1'b0) hits++;
    end
    total++; if (hits !== 0) begin bad++; $display("FAIL tmo_quiet got=%0d exp=0", hits); end
  endtask

  task automatic test_back_to_back();
    int n, seen, hits; bit ok;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1204; rom_mem[3] = 16'hFFFF;
    prep(1'b1, 10, 1'b1);
    pulse_start(n);
    total++; if ({busy, done, err} !== 3'b100) begin bad++; $display("FAIL rerun_clear got=%b exp=100", {busy, done, err}); end
    model_run(n, 10);
    ok = 1'b0; seen = -1;
    // Extra starts while busy, including one on the very edge busy falls.
    for (int i = 0; i < 200; i++) begin
      start = (cyc == n + 4 || cyc == n + 19 || cyc == exp_fin - 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; seen = cyc; break; end
    end
    start = 1'b0;
    total++; if (!ok || seen !== exp_fin) begin bad++; $display("FAIL rerun_finish got=%0d exp=%0d", seen, exp_fin); end
    total++; if (acc_q.size() !== exp_wr.size()) begin bad++; $display("FAIL rerun_count got=%0d exp=%0d", acc_q.size(), exp_wr.size()); end
    for (int i = 0; i < exp_wr.size() && i < acc_q.size(); i++) begin
      total++; if (acc_q[i] !== exp_wr[i] || acc_cyc[i] !== exp_acc[i]) begin
        bad++; $display("FAIL rerun_write%0d got=%h@%0d exp=%h@%0d", i, acc_q[i], acc_cyc[i], exp_wr[i], exp_acc[i]);
      end
    end
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b1) hits++;
    end
    total++; if (hits !== 0) begin bad++; $display("FAIL start_on_fall got=%0d exp=0", hits); end
  endtask

  task automatic test_overrun();
    int n, seen, back, prev; bit ok;
    fill_rom(16'h1180);
    prep(1'b1, 2, 1'b1);
    pulse_start(n);
    model_run(n, 2);
    ok = 1'b0; seen = -1; back = 0; prev = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (int'(rom_addr) < prev) back++;
      prev = int'(rom_addr);
      if (done === 1'b1) begin ok = 1'b1; seen = cyc; break; end
    end
    total++; if (!ok || seen !== exp_fin) begin bad++; $display("FAIL ovr_finish got=%0d exp=%0d", seen, exp_fin); end
    total++; if (acc_q.size() !== 256) begin bad++; $display("FAIL ovr_count got=%0d exp=256", acc_q.size()); end
    total++; if (back !== 0 || rom_addr !== 8'hFF) begin bad++; $display("FAIL ovr_addr got=%h back=%0d exp=ff back=0", rom_addr, back); end
    total++; if ({busy, done, err} !== {2'b01, exp_err}) begin bad++; $display("FAIL ovr_status got=%b exp=011", {busy, done, err}); end
    total++; if (acc_cyc.size() == 256 && acc_cyc[255] !== exp_acc[255]) begin
      bad++; $display("FAIL ovr_last_acc got=%0d exp=%0d", acc_cyc[255], exp_acc[255]);
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_random();
    test_stall();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
